// File: rtl/oam_dma_master.sv
// OAM DMA bus initiator: on a CPU write of a page number to TRIG_ADDR, halts
// the CPU and copies COUNT bytes from {page, idx} to the OAM data port,
// alternating one READ and one WRITE cycle per byte. An optional ALIGN cycle
// keeps every READ on an odd parity cycle.
module oam_dma_master #(
  parameter int                    WIDTH      = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] TRIG_ADDR  = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] DEST_ADDR  = 16'h2004,
  parameter int                    COUNT      = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  trig_we,
  input  logic [ADDR_WIDTH-1:0] trig_addr,
  input  logic [WIDTH-1:0]      trig_data,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_we,
  output logic [WIDTH-1:0]      bus_dout,
  input  logic [WIDTH-1:0]      bus_din,
  output logic                  cpu_halt,
  output logic                  busy,
  output logic                  done
);

  // Index of the last byte of a transfer; COUNT is a power of two <= 256.
  localparam logic [7:0] LAST_IDX = 8'(COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  state_e           state_q;
  logic [7:0]       page_q;
  logic [7:0]       idx_q;
  logic [WIDTH-1:0] data_q;
  logic             parity_q;
  logic             done_q;

  // Transfer sequencer, byte latch, parity toggle and completion pulse.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would let later lines see half-updated state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the data latch is reset too; it is only a handful of flops and
      // keeps bus_dout deterministic out of reset.
      state_q  <= S_IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (trig_we && (trig_addr == TRIG_ADDR)) begin
            page_q  <= trig_data[7:0];
            idx_q   <= '0;
            state_q <= S_HALT;
          end
        end
        // An odd-parity HALT needs one dummy cycle so READ lands on parity 1.
        S_HALT:  state_q <= parity_q ? S_ALIGN : S_READ;
        S_ALIGN: state_q <= S_READ;
        S_READ: begin
          data_q  <= bus_din;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (idx_q == LAST_IDX) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + 8'd1;
            state_q <= S_READ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Bus outputs are a pure decode of the current state and registers.
  // NOTE: every output gets a default before the case, so no latch is inferred.
  always_comb begin
    bus_addr = '0;
    bus_we   = 1'b0;
    bus_dout = '0;
    cpu_halt = (state_q != S_IDLE);
    case (state_q)
      S_READ:  bus_addr = ADDR_WIDTH'({page_q, idx_q});
      S_WRITE: begin
        bus_addr = DEST_ADDR;
        bus_we   = 1'b1;
        bus_dout = data_q;
      end
      default: ;
    endcase
  end

  assign busy = cpu_halt;
  assign done = done_q;

endmodule

// File: tb/tb_oam_dma_master.sv
// Randomized self-checking bench for oam_dma_master. A byte-array memory
// responder serves the bus; a monitor logs every write and the address read
// just before it; each transfer is compared against the expected page
// contents and the busy length implied by the HALT cycle parity.
module tb_oam_dma_master;

  logic        clk;
  logic        reset_n;
  logic        trig_we;
  logic [15:0] trig_addr;
  logic [7:0]  trig_data;
  logic [15:0] bus_addr;
  logic        bus_we;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        cpu_halt;
  logic        busy;
  logic        done;

  oam_dma_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .trig_we   (trig_we),
    .trig_addr (trig_addr),
    .trig_data (trig_data),
    .bus_addr  (bus_addr),
    .bus_we    (bus_we),
    .bus_dout  (bus_dout),
    .bus_din   (bus_din),
    .cpu_halt  (cpu_halt),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: combinational read, write on the rising edge.
  logic [7:0] mem [0:65535];
  assign bus_din = mem[bus_addr];
  always @(posedge clk) if (bus_we) mem[bus_addr] <= bus_dout;

  // Parity reference: clock edges since the last reset edge, modulo 2.
  int par_edges = 0;
  always @(posedge clk) begin
    if (!reset_n) par_edges = 0;
    else          par_edges = par_edges + 1;
  end

  // Scoreboard state filled in by the monitor.
  logic [7:0]  wr_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] prev_addr = '0;
  int busy_cycles = 0;
  int done_cnt    = 0;
  int bad_dest    = 0;
  int idle_bad    = 0;
  int halt_busy   = 0;
  int done_busy   = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: samples outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (done) done_cnt++;
    if (cpu_halt !== busy) halt_busy++;
    if (done && busy) done_busy++;
    if (!busy && (bus_we || bus_addr != 0 || bus_dout != 0)) idle_bad++;
    if (bus_we) begin
      wr_q.push_back(bus_dout);
      rd_q.push_back(prev_addr);
      if (bus_addr != 16'h2004) bad_dest++;
    end
    prev_addr = bus_addr;
  end

  task automatic clear_stats();
    wr_q.delete();
    rd_q.delete();
    busy_cycles = 0;
    done_cnt    = 0;
    bad_dest    = 0;
  endtask

  task automatic pulse_trig(input logic [15:0] a, input logic [7:0] d);
    trig_we   = 1'b1;
    trig_addr = a;
    trig_data = d;
    @(negedge clk);
    trig_we   = 1'b0;
    trig_addr = '0;
    trig_data = '0;
  endtask

  // Wait (bounded) for a READ of the given address to be on the bus.
  task automatic wait_read(input logic [15:0] a, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 700; k++) begin
      if (busy && !bus_we && bus_addr == a) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One full transfer of 'page' whose HALT cycle has parity h.
  // inject: 0 none, 1 retrigger page $07 at idx $40, 2 retrigger in final WRITE.
  task automatic do_dma(input logic [7:0] page, input bit h, input int inject);
    logic [7:0] exp_data [256];
    bit ok;
    int nbad_rd, nbad_wr, n;
    for (int i = 0; i < 256; i++) exp_data[i] = mem[{page, 8'(i)}];
    @(posedge clk);
    #1 clear_stats();
    @(negedge clk);
    // Trigger is sampled at the next edge; HALT parity is then the current one flipped.
    while ((par_edges % 2) != (h ? 0 : 1)) @(negedge clk);
    pulse_trig(16'h4014, page);
    if (inject == 1) begin
      wait_read({page, 8'h40}, ok);
      check("inject_mid_reached", ok, 1);
      pulse_trig(16'h4014, 8'h07);
    end else if (inject == 2) begin
      wait_read({page, 8'hFF}, ok);
      check("inject_last_reached", ok, 1);
      @(negedge clk);
      pulse_trig(16'h4014, 8'h5A);
    end
    ok = 1'b0;
    for (int k = 0; k < 700; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", ok, 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    nbad_rd = 0;
    nbad_wr = 0;
    n = (wr_q.size() < 256) ? wr_q.size() : 256;
    for (int i = 0; i < n; i++) begin
      if (rd_q[i] !== {page, 8'(i)}) nbad_rd++;
      if (wr_q[i] !== exp_data[i]) nbad_wr++;
    end
    check("busy_len", busy_cycles, 32'(513 + int'(h)));
    check("done_pulses", done_cnt, 1);
    check("wr_count", wr_q.size(), 256);
    check("wr_dest", bad_dest, 0);
    check("rd_addr_bad", nbad_rd, 0);
    check("wr_data_bad", nbad_wr, 0);
  endtask

  initial begin
    logic [7:0] pg;
    bit ok;
    int wr_at_rst;
    trig_we   = 1'b0;
    trig_addr = '0;
    trig_data = '0;
    reset_n   = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;

    // Reset and idle behaviour.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_dout", bus_dout, 0);
    check("rst_cpu_halt", cpu_halt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    clear_stats();
    repeat (10) @(negedge clk);
    check("idle_writes", wr_q.size(), 0);
    check("idle_done", done_cnt, 0);
    check("idle_busy", busy_cycles, 0);

    // Page $02 with HALT at parity 0, then parity 1 with a retrigger in the final WRITE.
    do_dma(8'h02, 1'b0, 0);
    check("first_wr0", wr_q[0], 8'hA5);
    check("first_wr1", wr_q[1], 8'hA4);
    check("first_wr2", wr_q[2], 8'hA7);
    do_dma(8'h02, 1'b1, 2);
    check("p1_wr2", wr_q[2], 8'hA7);

    // Retrigger mid-transfer is ignored.
    do_dma(8'h03, 1'($urandom), 1);

    // Wrong trigger address starts nothing; page $00 works.
    @(posedge clk);
    #1 clear_stats();
    @(negedge clk);
    pulse_trig(16'h4015, 8'h02);
    repeat (20) @(negedge clk);
    check("wrong_addr_busy", busy_cycles, 0);
    check("wrong_addr_writes", wr_q.size(), 0);
    do_dma(8'h00, 1'($urandom), 0);

    // Random pages and parities.
    for (int r = 0; r < 3; r++) begin
      pg = 8'($urandom_range(0, 255));
      if (pg == 8'h20) pg = 8'h21;
      do_dma(pg, 1'($urandom), 0);
    end

    // Reset during the WRITE of idx $80.
    pg = 8'($urandom_range(0, 255));
    if (pg == 8'h20) pg = 8'h21;
    @(posedge clk);
    #1 clear_stats();
    @(negedge clk);
    pulse_trig(16'h4014, pg);
    wait_read({pg, 8'h80}, ok);
    check("rst_mid_reached", ok, 1);
    @(negedge clk);
    check("rst_mid_in_write", bus_we, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_mid_halt", cpu_halt, 0);
    check("rst_mid_busy", busy, 0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    check("rst_mid_writes", wr_q.size(), 129);
    check("rst_mid_done", done_cnt, 0);
    do_dma(pg, 1'($urandom), 0);

    check("idle_outputs_bad", idle_bad, 0);
    check("halt_ne_busy", halt_busy, 0);
    check("done_while_busy", done_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
